// File: rtl/dti_reg_pkg.sv
// dti_reg_pkg: state encodings shared by the DTI register slices
package dti_reg_pkg;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} dskid_state_t;
  typedef enum logic {PASS, SKID} dskid_skid_t;
endpackage

// File: rtl/dti_if.sv
// dti_if: valid/ready handshake bundle; snk faces the producer, src faces the consumer
interface dti_if #(parameter int W = 8) ();
  logic [W-1:0] data;
  logic         valid;
  logic         ready;
  modport snk (input data, input valid, output ready);
  modport src (output data, output valid, input ready);
endinterface

// File: rtl/dskid.sv
// dskid: registered-ready skid slice; FWD_REG=1 adds an output register for two-entry decoupling
module dskid
  import dti_reg_pkg::*;
#(
  parameter bit FWD_REG = 1'b0
) (
  input logic clk,
  input logic rst,
  dti_if.snk  din,
  dti_if.src  dout
);
  localparam int W = $bits(din.data);
  if ($bits(din.data) != $bits(dout.data)) begin : g_bad
    $error("dskid: din/dout width mismatch");
  end
  logic [W-1:0] s_q, s_d;
  logic         cap;
  always_comb s_d = cap ? din.data : s_q;
  always_ff @(posedge clk) s_q <= s_d;
  if (!FWD_REG) begin : g_pass
    dskid_skid_t st_q, st_d;
    always_comb begin
      cap  = (st_q == PASS) && din.valid && !dout.ready;
      st_d = (st_q == PASS) ? (cap ? SKID : PASS) : (dout.ready ? PASS : SKID);
    end
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) st_q <= PASS;
      else      st_q <= st_d;
    end
    // rst gates the pass-through valid so nothing escapes while reset is held
    assign din.ready  = st_q == PASS;
    assign dout.valid = rst && ((st_q == SKID) || din.valid);
    assign dout.data  = (st_q == PASS) ? din.data : s_q;
  end else begin : g_fwd
    dskid_state_t st_q, st_d;
    logic [W-1:0] o_q, o_d;
    logic         acc;
    always_comb begin
      acc  = din.valid && (st_q != TWO);
      cap  = acc && (st_q == ONE) && !dout.ready;
      o_d  = (acc && ((st_q == EMPTY) || dout.ready)) ? din.data :
             ((st_q == TWO) && dout.ready) ? s_q : o_q;
      st_d = (st_q == EMPTY) ? (acc ? ONE : EMPTY) :
             (st_q == ONE)   ? (cap ? TWO : (dout.ready && !acc) ? EMPTY : ONE) :
             (dout.ready ? ONE : TWO);
    end
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) st_q <= EMPTY;
      else      st_q <= st_d;
    end
    always_ff @(posedge clk) o_q <= o_d;
    assign din.ready  = st_q != TWO;
    assign dout.valid = st_q != EMPTY;
    assign dout.data  = o_q;
  end
endmodule

// File: tb/tb_dskid.sv
// tb_dskid: directed checks of both dskid variants, one selected at a time through sel
module tb_dskid;
  logic       clk = 1'b0, rst = 1'b0, sel = 1'b0, dv = 1'b0, dr = 1'b0;
  logic [7:0] dd = 8'h00;
  int         checks = 0, errors = 0;
  always #5 clk = ~clk;
  dti_if #(.W(8)) i0 (), o0 (), i1 (), o1 ();
  assign i0.valid = dv & ~sel;
  assign i0.data  = dd;
  assign o0.ready = dr;
  assign i1.valid = dv & sel;
  assign i1.data  = dd;
  assign o1.ready = dr;
  dskid #(.FWD_REG(1'b0)) u0 (.clk(clk), .rst(rst), .din(i0), .dout(o0));
  dskid #(.FWD_REG(1'b1)) u1 (.clk(clk), .rst(rst), .din(i1), .dout(o1));
  logic       ir, ov;
  logic [7:0] od;
  assign ir = sel ? i1.ready : i0.ready;
  assign ov = sel ? o1.valid : o0.valid;
  assign od = sel ? o1.data  : o0.data;
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s fwd=%0d observed=%h expected=%h", tag, sel, obs, exp);
    end
  endtask
  task automatic set(input logic v, input logic [7:0] d, input logic r);
    @(negedge clk);
    dv = v; dd = d; dr = r;
    #1;
  endtask
  task automatic step(input logic v, input logic [7:0] d, input logic r,
                      input logic eir, input logic eov, input logic [7:0] eod, input string tag);
    set(v, d, r);
    chk({tag, "_ready"}, {7'd0, ir}, {7'd0, eir});
    chk({tag, "_valid"}, {7'd0, ov}, {7'd0, eov});
    if (eov) chk({tag, "_data"}, od, eod);
  endtask
  task automatic run(input bit f);
    int         nxt, oc;
    logic       hv;
    logic [7:0] hd;
    sel = f;
    step(0, 8'h00, 1, 1, 0, 8'h00, "idle");
    @(negedge clk);
    dv = 1; dr = 1; #1;
    chk("comb_ready_hi", {7'd0, ir}, 8'd1);
    dr = 0; #1;
    chk("comb_ready_lo", {7'd0, ir}, 8'd1);
    dv = 0; dr = 1;
    for (int i = 0; i < 16; i++)
      step(1, 8'(i), 1, 1, f ? 1'(i > 0) : 1'b1, f ? 8'(i - 1) : 8'(i), "stream");
    step(0, 8'h00, 1, 1, f, 8'd15, "stream_tail");
    step(0, 8'h00, 1, 1, 0, 8'h00, "stream_idle");
    if (f) begin
      step(1, 8'h11, 0, 1, 0, 8'h00, "stall0");
      step(1, 8'h22, 0, 1, 1, 8'h11, "stall1");
      step(1, 8'h33, 0, 0, 1, 8'h11, "stall2");
      step(1, 8'h33, 0, 0, 1, 8'h11, "stall3");
      step(1, 8'h33, 1, 0, 1, 8'h11, "drain0");
      step(1, 8'h33, 1, 1, 1, 8'h22, "drain1");
      step(0, 8'h00, 1, 1, 1, 8'h33, "drain2");
    end else begin
      step(1, 8'h11, 0, 1, 1, 8'h11, "stall0");
      step(1, 8'h22, 0, 0, 1, 8'h11, "stall1");
      step(1, 8'h22, 0, 0, 1, 8'h11, "stall2");
      step(1, 8'h22, 1, 0, 1, 8'h11, "drain0");
      step(1, 8'h22, 1, 1, 1, 8'h22, "drain1");
      step(1, 8'h33, 1, 1, 1, 8'h33, "drain2");
    end
    step(0, 8'h00, 1, 1, 0, 8'h00, "stall_idle");
    nxt = 0; oc = 0; hv = 0; hd = 8'h00;
    for (int k = 0; k < 200 && oc < 32; k++) begin
      set(nxt < 32, 8'(nxt), (k % 2) == 0);
      if (hv) begin
        chk("hold_valid", {7'd0, ov}, 8'd1);
        chk("hold_data", od, hd);
      end
      if (ov && dr) begin
        chk("toggle_data", od, 8'(oc));
        oc++;
      end
      hv = ov && !dr;
      hd = od;
      if (dv && ir) nxt++;
    end
    chk("toggle_count", 8'(oc), 8'd32);
    step(0, 8'h00, 1, 1, 0, 8'h00, "toggle_idle");
    step(1, 8'h5A, 0, 1, !f, 8'h5A, "mid0");
    step(1, 8'h6B, 0, f, 1, 8'h5A, "mid1");
    if (f) step(1, 8'h7C, 0, 0, 1, 8'h5A, "mid2");
    dr = 1; #1;
    chk("ready_indep", {7'd0, ir}, 8'd0);
    dr = 0; #1;
    rst = 0; #1;
    chk("async_valid", {7'd0, ov}, 8'd0);
    chk("async_ready", {7'd0, ir}, 8'd1);
    @(negedge clk);
    rst = 1; dv = 0; dr = 1; #1;
    chk("release_valid", {7'd0, ov}, 8'd0);
    step(0, 8'h00, 1, 1, 0, 8'h00, "post_reset");
  endtask
  initial begin
    rst = 0; dv = 1; dd = 8'hA5; dr = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      sel = k[0]; #1;
      chk("rst_valid0", {7'd0, o0.valid}, 8'd0);
      chk("rst_ready0", {7'd0, i0.ready}, 8'd1);
      chk("rst_valid1", {7'd0, o1.valid}, 8'd0);
      chk("rst_ready1", {7'd0, i1.ready}, 8'd1);
    end
    @(negedge clk);
    sel = 0; rst = 1; #1;
    chk("release_pass_valid", {7'd0, o0.valid}, 8'd1);
    chk("release_pass_data", o0.data, 8'hA5);
    run(1'b0);
    run(1'b1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
